vertex_smooth: RTL and testbench

VERTEX_SMOOTH -- requirements
Module: vertex_smooth

---
 rtl/subdiv_pkg.sv | 63 ++++++
 rtl/smooth_axis.sv | 28 ++
 rtl/vertex_smooth.sv | 260 ++++++++++++++++++++++++++
 tb/tb_vertex_smooth.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subdiv_pkg.sv
// Shared definitions for the subdivision/smoothing blocks: FSM states,
// RAM address map and the Loop-style smoothing weight table.
package subdiv_pkg;

  localparam int COORD_W = 32;  // signed fixed-point coordinate
  localparam int ACC_W   = 40;  // per-axis neighbor sum
  localparam int PROD_W  = 56;  // (sum - n*v) * beta
  localparam int ADDR_W  = 9;   // all RAMs are 512 words deep
  localparam int BETA_W  = 16;  // unsigned Q0.16 weight

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_CNT,
    S_RD_NID,
    S_RD_NPOS,
    S_RD_SELF,
    S_CALC,
    S_WR,
    S_NEXT,
    S_DONE
  } state_e;

  // Vertex ids are 1-based; id 0 wraps to the top of the address space.
  function automatic logic [ADDR_W-1:0] obj_addr(input logic [31:0] vid,
                                                 input logic [1:0]  k);
    return ADDR_W'(32'd2 + 32'd3 * (vid - 32'd1) + 32'(k));
  endfunction

  function automatic logic [ADDR_W-1:0] nbr_cnt_addr(input logic [31:0] vid,
                                                     input logic [31:0] slots);
    return ADDR_W'((vid - 32'd1) * slots);
  endfunction

  function automatic logic [ADDR_W-1:0] nbr_id_addr(input logic [31:0] vid,
                                                    input logic [31:0] j,
                                                    input logic [31:0] slots);
    return ADDR_W'((vid - 32'd1) * slots + 32'd1 + j);
  endfunction

  function automatic logic [ADDR_W-1:0] out_addr(input logic [31:0] vid,
                                                 input logic [1:0]  k);
    return ADDR_W'(32'd3 * (vid - 32'd1) + 32'(k));
  endfunction

  // floor(3/(8n)) in Q0.16, except n=3 which uses 3/16; n=0 means no smoothing.
  function automatic logic [BETA_W-1:0] beta_q16(input logic [31:0] n);
    case (n)
      32'd0:   return 16'd0;
      32'd1:   return 16'd24576;
      32'd2:   return 16'd12288;
      32'd3:   return 16'd12288;
      32'd4:   return 16'd6144;
      32'd5:   return 16'd4915;
      32'd6:   return 16'd4096;
      32'd7:   return 16'd3510;
      32'd8:   return 16'd3072;
      32'd9:   return 16'd2730;
      32'd10:  return 16'd2457;
      default: return BETA_W'(32'd24576 / n);
    endcase
  endfunction

endpackage

// File: rtl/smooth_axis.sv
// One axis of the smoothing update: new = v + ((sum - n*v) * beta) >>> FRAC_BITS.
module smooth_axis
  import subdiv_pkg::*;
#(
  parameter int FRAC_BITS = 16,
  parameter int CNT_W     = 4
) (
  input  logic signed [COORD_W-1:0] v_i,
  input  logic signed [ACC_W-1:0]   sum_i,
  input  logic        [CNT_W-1:0]   n_i,
  input  logic        [BETA_W-1:0]  beta_i,
  output logic signed [COORD_W-1:0] new_o
);

  logic signed [ACC_W-1:0]  v_ext;
  logic signed [ACC_W-1:0]  n_ext;
  logic signed [ACC_W-1:0]  diff;
  logic signed [PROD_W-1:0] prod;

  assign v_ext = ACC_W'(v_i);
  assign n_ext = $signed(ACC_W'(n_i));
  assign diff  = sum_i - n_ext * v_ext;
  assign prod  = PROD_W'(diff) * $signed(PROD_W'(beta_i));

  // Arithmetic shift floors toward -inf; the sum wraps to the coordinate width.
  assign new_o = (n_i == '0) ? v_i : v_i + COORD_W'(prod >>> FRAC_BITS);

endmodule

// File: rtl/vertex_smooth.sv
// Smooths every vertex toward the centroid of its neighbor ring, reading
// positions and neighbor lists from two synchronous RAMs and writing the
// new positions to a third.
module vertex_smooth
  import subdiv_pkg::*;
#(
  parameter int MAX_NEIGHBOR_COUNT = 10,
  parameter int FRAC_BITS          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] vertex_count,
  output logic        RAM_OBJ_EN,
  output logic [8:0]  RAM_OBJ_A,
  output logic [3:0]  RAM_OBJ_WE,
  output logic [31:0] RAM_OBJ_Di,
  input  logic [31:0] RAM_OBJ_Do,
  output logic        RAM_NBR_EN,
  output logic [8:0]  RAM_NBR_A,
  output logic [3:0]  RAM_NBR_WE,
  output logic [31:0] RAM_NBR_Di,
  input  logic [31:0] RAM_NBR_Do,
  output logic        RAM_OUT_EN,
  output logic [8:0]  RAM_OUT_A,
  output logic [3:0]  RAM_OUT_WE,
  output logic [31:0] RAM_OUT_Di,
  output logic        busy,
  output logic        done
);

  localparam int          CNT_W = $clog2(MAX_NEIGHBOR_COUNT + 1);
  localparam logic [31:0] SLOTS = 32'(MAX_NEIGHBOR_COUNT);

  state_e                     state_q;
  logic                       phase_q;    // 0: address on bus, 1: data on Do
  logic [1:0]                 axis_q;
  logic [31:0]                vtx_q;
  logic [31:0]                vcnt_q;
  logic [31:0]                nid_q;
  logic [CNT_W-1:0]           n_q;
  logic [CNT_W-1:0]           nbr_idx_q;
  logic signed [ACC_W-1:0]    acc_q  [3];
  logic signed [COORD_W-1:0]  self_q [3];
  logic signed [COORD_W-1:0]  res_q  [3];
  logic signed [COORD_W-1:0]  axis_new [3];

  logic                       obj_en_q, nbr_en_q, out_en_q;
  logic [ADDR_W-1:0]          obj_a_q, nbr_a_q, out_a_q;
  logic [3:0]                 out_we_q;
  logic [COORD_W-1:0]         out_di_q;
  logic                       busy_q, done_q;

  logic [CNT_W-1:0]           n_clamped;
  logic [BETA_W-1:0]          beta;

  // Read-only RAMs never see write strobes or data.
  assign RAM_OBJ_WE = 4'b0000;
  assign RAM_OBJ_Di = 32'd0;
  assign RAM_NBR_WE = 4'b0000;
  assign RAM_NBR_Di = 32'd0;

  assign RAM_OBJ_EN = obj_en_q;
  assign RAM_OBJ_A  = obj_a_q;
  assign RAM_NBR_EN = nbr_en_q;
  assign RAM_NBR_A  = nbr_a_q;
  assign RAM_OUT_EN = out_en_q;
  assign RAM_OUT_A  = out_a_q;
  assign RAM_OUT_WE = out_we_q;
  assign RAM_OUT_Di = out_di_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // An oversized count word is clamped to the slot capacity of the list.
  assign n_clamped = (RAM_NBR_Do > SLOTS) ? CNT_W'(MAX_NEIGHBOR_COUNT)
                                          : CNT_W'(RAM_NBR_Do);
  assign beta      = beta_q16(32'(n_q));

  for (genvar a = 0; a < 3; a++) begin : g_axis
    smooth_axis #(
      .FRAC_BITS (FRAC_BITS),
      .CNT_W     (CNT_W)
    ) u_axis (
      .v_i    (self_q[a]),
      .sum_i  (acc_q[a]),
      .n_i    (n_q),
      .beta_i (beta),
      .new_o  (axis_new[a])
    );
  end

  // Pass sequencer: issues one RAM access per read state, captures data one
  // cycle later, then computes and writes the three smoothed components.
  // NOTE: every register here is assigned with <= so all reads see the
  // pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      axis_q    <= 2'd0;
      vtx_q     <= 32'd0;
      vcnt_q    <= 32'd0;
      nid_q     <= 32'd0;
      n_q       <= '0;
      nbr_idx_q <= '0;
      // NOTE: these three-entry arrays are plain flops, not RAM, so they are
      // reset like any other state to keep the datapath deterministic.
      acc_q     <= '{default: '0};
      self_q    <= '{default: '0};
      res_q     <= '{default: '0};
      obj_en_q  <= 1'b0;
      nbr_en_q  <= 1'b0;
      out_en_q  <= 1'b0;
      obj_a_q   <= '0;
      nbr_a_q   <= '0;
      out_a_q   <= '0;
      out_we_q  <= 4'b0000;
      out_di_q  <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      obj_en_q <= 1'b0;
      nbr_en_q <= 1'b0;
      out_en_q <= 1'b0;
      out_we_q <= 4'b0000;
      done_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            vcnt_q  <= vertex_count;
            phase_q <= 1'b0;
            if (vertex_count == 32'd0) begin
              state_q <= S_DONE;
            end else begin
              vtx_q    <= 32'd1;
              state_q  <= S_RD_CNT;
              nbr_en_q <= 1'b1;
              nbr_a_q  <= nbr_cnt_addr(32'd1, SLOTS);
            end
          end
        end

        S_RD_CNT: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            acc_q   <= '{default: '0};
          end else begin
            phase_q   <= 1'b0;
            axis_q    <= 2'd0;
            nbr_idx_q <= '0;
            n_q       <= n_clamped;
            if (n_clamped == '0) begin
              state_q  <= S_RD_SELF;
              obj_en_q <= 1'b1;
              obj_a_q  <= obj_addr(vtx_q, 2'd0);
            end else begin
              state_q  <= S_RD_NID;
              nbr_en_q <= 1'b1;
              nbr_a_q  <= nbr_id_addr(vtx_q, 32'd0, SLOTS);
            end
          end
        end

        S_RD_NID: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
          end else begin
            phase_q  <= 1'b0;
            nid_q    <= RAM_NBR_Do;
            axis_q   <= 2'd0;
            state_q  <= S_RD_NPOS;
            obj_en_q <= 1'b1;
            obj_a_q  <= obj_addr(RAM_NBR_Do, 2'd0);
          end
        end

        S_RD_NPOS: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
          end else begin
            phase_q        <= 1'b0;
            acc_q[axis_q]  <= acc_q[axis_q] + ACC_W'($signed(RAM_OBJ_Do));
            if (axis_q != 2'd2) begin
              axis_q   <= axis_q + 2'd1;
              obj_en_q <= 1'b1;
              obj_a_q  <= obj_addr(nid_q, axis_q + 2'd1);
            end else if ((nbr_idx_q + CNT_W'(1)) == n_q) begin
              axis_q   <= 2'd0;
              state_q  <= S_RD_SELF;
              obj_en_q <= 1'b1;
              obj_a_q  <= obj_addr(vtx_q, 2'd0);
            end else begin
              nbr_idx_q <= nbr_idx_q + CNT_W'(1);
              state_q   <= S_RD_NID;
              nbr_en_q  <= 1'b1;
              nbr_a_q   <= nbr_id_addr(vtx_q, 32'(nbr_idx_q) + 32'd1, SLOTS);
            end
          end
        end

        S_RD_SELF: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
          end else begin
            phase_q        <= 1'b0;
            self_q[axis_q] <= $signed(RAM_OBJ_Do);
            if (axis_q != 2'd2) begin
              axis_q   <= axis_q + 2'd1;
              obj_en_q <= 1'b1;
              obj_a_q  <= obj_addr(vtx_q, axis_q + 2'd1);
            end else begin
              state_q <= S_CALC;
            end
          end
        end

        S_CALC: begin
          res_q   <= axis_new;
          axis_q  <= 2'd0;
          state_q <= S_WR;
        end

        S_WR: begin
          out_en_q <= 1'b1;
          out_we_q <= 4'b1111;
          out_a_q  <= out_addr(vtx_q, axis_q);
          out_di_q <= res_q[axis_q];
          if (axis_q == 2'd2) begin
            state_q <= S_NEXT;
          end else begin
            axis_q <= axis_q + 2'd1;
          end
        end

        S_NEXT: begin
          if (vtx_q == vcnt_q) begin
            state_q <= S_DONE;
          end else begin
            vtx_q    <= vtx_q + 32'd1;
            state_q  <= S_RD_CNT;
            nbr_en_q <= 1'b1;
            nbr_a_q  <= nbr_cnt_addr(vtx_q + 32'd1, SLOTS);
          end
        end

        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_smooth.sv
// Directed bench for vertex_smooth: behavioral RAMs, a scoreboard of
// expected OUT-RAM writes, and read/done/write activity counters.
module tb_vertex_smooth;

  localparam int MAXN = 10;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] vertex_count = 32'd0;
  logic        RAM_OBJ_EN, RAM_NBR_EN, RAM_OUT_EN;
  logic [8:0]  RAM_OBJ_A, RAM_NBR_A, RAM_OUT_A;
  logic [3:0]  RAM_OBJ_WE, RAM_NBR_WE, RAM_OUT_WE;
  logic [31:0] RAM_OBJ_Di, RAM_NBR_Di, RAM_OUT_Di;
  logic [31:0] RAM_OBJ_Do, RAM_NBR_Do;
  logic        busy, done;

  logic [31:0] obj_mem [512];
  logic [31:0] nbr_mem [512];
  logic [31:0] out_mem [512];

  exp_t        sb [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          obj_reads = 0, nbr_reads = 0, writes = 0, done_pulses = 0;
  logic [8:0]  first_nbr_a = '0;
  logic        v2_write_seen = 1'b0;

  always #5 clk = ~clk;

  vertex_smooth #(.MAX_NEIGHBOR_COUNT(MAXN), .FRAC_BITS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vertex_count (vertex_count),
    .RAM_OBJ_EN   (RAM_OBJ_EN),
    .RAM_OBJ_A    (RAM_OBJ_A),
    .RAM_OBJ_WE   (RAM_OBJ_WE),
    .RAM_OBJ_Di   (RAM_OBJ_Di),
    .RAM_OBJ_Do   (RAM_OBJ_Do),
    .RAM_NBR_EN   (RAM_NBR_EN),
    .RAM_NBR_A    (RAM_NBR_A),
    .RAM_NBR_WE   (RAM_NBR_WE),
    .RAM_NBR_Di   (RAM_NBR_Di),
    .RAM_NBR_Do   (RAM_NBR_Do),
    .RAM_OUT_EN   (RAM_OUT_EN),
    .RAM_OUT_A    (RAM_OUT_A),
    .RAM_OUT_WE   (RAM_OUT_WE),
    .RAM_OUT_Di   (RAM_OUT_Di),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Synchronous RAMs: data for the address seen at an edge is valid the next cycle.
  always @(posedge clk) begin
    if (RAM_OBJ_EN) RAM_OBJ_Do <= obj_mem[RAM_OBJ_A];
    if (RAM_NBR_EN) RAM_NBR_Do <= nbr_mem[RAM_NBR_A];
    if (RAM_OUT_EN && RAM_OUT_WE == 4'hF) out_mem[RAM_OUT_A] <= RAM_OUT_Di;
  end

  // Monitor away from the active edge: activity counters and scoreboard pops.
  always @(negedge clk) begin
    if (RAM_OBJ_EN) obj_reads++;
    if (RAM_NBR_EN) begin
      if (nbr_reads == 0) first_nbr_a = RAM_NBR_A;
      nbr_reads++;
    end
    if (done) done_pulses++;
    if (RAM_OUT_EN) begin
      writes++;
      if (RAM_OUT_A == 9'd3) v2_write_seen = 1'b1;
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        check("out_addr", 64'(RAM_OUT_A), 64'(mon_e.addr));
        check("out_data", 64'(RAM_OUT_Di), 64'(mon_e.data));
        check("out_we", 64'(RAM_OUT_WE), 64'hF);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int oaddr(input logic [31:0] id, input int k);
    return int'((32'd2 + 32'd3 * (id - 32'd1) + 32'(k)) & 32'h1FF);
  endfunction

  function automatic logic [31:0] model_axis(input logic [31:0] v, input longint sum, input int n);
    longint bt [0:10] = '{0, 24576, 12288, 12288, 6144, 4915, 4096, 3510, 3072, 2730, 2457};
    longint sv, diff, prod;
    sv = longint'($signed(v));
    if (n == 0) return v;
    diff = sum - longint'(n) * sv;
    prod = diff * bt[n];
    return 32'(sv + (prod >>> 16));
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) begin
      obj_mem[i] = 32'd0;
      nbr_mem[i] = 32'd0;
      out_mem[i] = 32'hDEADBEEF;
    end
  endtask

  task automatic clear_counters();
    obj_reads = 0; nbr_reads = 0; writes = 0; done_pulses = 0;
  endtask

  task automatic set_pos(input int v, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    obj_mem[oaddr(32'(v), 0)] = x;
    obj_mem[oaddr(32'(v), 1)] = y;
    obj_mem[oaddr(32'(v), 2)] = z;
  endtask

  task automatic set_count(input int v, input logic [31:0] c);
    nbr_mem[((v - 1) * MAXN) & 511] = c;
  endtask

  task automatic set_id(input int v, input int j, input logic [31:0] id);
    nbr_mem[((v - 1) * MAXN + 1 + j) & 511] = id;
  endtask

  task automatic push_exp(input int a, input logic [31:0] d);
    sb.push_back('{addr: 9'(a), data: d});
  endtask

  // Expected writes for vertex v from the bench's own memory images.
  task automatic push_vertex(input int v, input int naxes);
    logic [31:0] cnt, id;
    longint      sum [3];
    int          n;
    cnt = nbr_mem[((v - 1) * MAXN) & 511];
    n = (cnt > 32'(MAXN)) ? MAXN : int'(cnt);
    for (int k = 0; k < 3; k++) sum[k] = 0;
    for (int j = 0; j < n; j++) begin
      id = nbr_mem[((v - 1) * MAXN + 1 + j) & 511];
      for (int k = 0; k < 3; k++) sum[k] += longint'($signed(obj_mem[oaddr(id, k)]));
    end
    for (int k = 0; k < naxes; k++)
      push_exp(3 * (v - 1) + k, model_axis(obj_mem[oaddr(32'(v), k)], sum[k], n));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_pass(input string tag, input int budget);
    int d0, i;
    d0 = done_pulses;
    i = 0;
    while (done_pulses == d0 && i < budget) begin
      step();
      i++;
    end
    check({tag, "_done_seen"}, 64'(done_pulses - d0), 64'd1);
    step();
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    int wr_at_reset;
    logic [31:0] rx, ry, rz;
    clear_mem();

    // Reset state.
    rst_n = 1'b0;
    step(); step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_en", 64'({RAM_OBJ_EN, RAM_NBR_EN, RAM_OUT_EN}), 64'd0);
    check("rst_we", 64'({RAM_OBJ_WE, RAM_NBR_WE, RAM_OUT_WE}), 64'd0);
    check("rst_addr", 64'({RAM_OBJ_A, RAM_NBR_A, RAM_OUT_A}), 64'd0);
    rst_n = 1'b1;
    step();

    // Empty mesh: straight to DONE, no RAM traffic, done two cycles after start.
    vertex_count = 32'd0;
    clear_counters();
    pulse_start();
    check("empty_busy_c1", 64'(busy), 64'd1);
    check("empty_done_c1", 64'(done), 64'd0);
    step();
    check("empty_done_c2", 64'(done), 64'd1);
    check("empty_busy_c2", 64'(busy), 64'd0);
    step();
    check("empty_done_c3", 64'(done), 64'd0);
    check("empty_no_ram", 64'(obj_reads + nbr_reads + writes), 64'd0);

    // Three neighbors along x; second vertex has no neighbors and passes through.
    clear_mem();
    set_pos(1, 32'h0, 32'h0, 32'h0);
    set_pos(2, 32'h00010000, 32'h0, 32'h0);
    set_pos(3, 32'h00020000, 32'h0, 32'h0);
    set_pos(4, 32'h00030000, 32'h0, 32'h0);
    set_count(1, 32'd3);
    set_id(1, 0, 32'd2); set_id(1, 1, 32'd3); set_id(1, 2, 32'd4);
    set_count(2, 32'd0);
    push_exp(0, 32'h00012000); push_exp(1, 32'h0); push_exp(2, 32'h0);
    push_exp(3, 32'h00010000); push_exp(4, 32'h0); push_exp(5, 32'h0);
    vertex_count = 32'd2;
    clear_counters();
    pulse_start();
    run_pass("n3", 600);
    check("n3_nbr_reads", 64'(nbr_reads), 64'd5);
    check("n3_obj_reads", 64'(obj_reads), 64'd15);

    // Six zero neighbors: pulls the vertex toward the origin, incl. negative axis.
    clear_mem();
    set_pos(1, 32'h00100000, 32'hFFFF0000, 32'h00008000);
    set_count(1, 32'd6);
    for (int j = 0; j < 6; j++) set_id(1, j, 32'(j + 2));
    push_exp(0, 32'h000A0000); push_exp(1, 32'hFFFF6000); push_exp(2, 32'h00005000);
    vertex_count = 32'd1;
    clear_counters();
    pulse_start();
    run_pass("n6", 600);

    // Count word 15 clamps to 10 neighbors; random coordinates.
    clear_mem();
    set_pos(1, $urandom, $urandom, $urandom);
    set_count(1, 32'd15);
    for (int j = 0; j < 10; j++) begin
      set_id(1, j, 32'(j + 2));
      set_pos(j + 2, $urandom, $urandom, $urandom);
    end
    push_vertex(1, 3);
    vertex_count = 32'd1;
    clear_counters();
    pulse_start();
    run_pass("clamp", 1000);
    check("clamp_nbr_reads", 64'(nbr_reads), 64'd11);
    check("clamp_obj_reads", 64'(obj_reads), 64'd33);

    // Reset while vertex 2 is being written.
    clear_mem();
    rx = $urandom; ry = $urandom; rz = $urandom;
    set_pos(1, rx, ry, rz);
    set_pos(2, 32'h00040000, 32'hFFFE0000, 32'h00001234);
    set_pos(3, 32'h7FFF0000, 32'h80000000, 32'h0);
    set_count(1, 32'd1); set_id(1, 0, 32'd2);
    set_count(2, 32'd1); set_id(2, 0, 32'd3);
    set_count(3, 32'd1); set_id(3, 0, 32'd1);
    push_vertex(1, 3);
    push_vertex(2, 1);
    vertex_count = 32'd3;
    v2_write_seen = 1'b0;
    clear_counters();
    pulse_start();
    for (int i = 0; i < 400 && !v2_write_seen; i++) step();
    check("mid_v2_write_reached", 64'(v2_write_seen), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_en", 64'({RAM_OBJ_EN, RAM_NBR_EN, RAM_OUT_EN}), 64'd0);
    check("mid_rst_we", 64'(RAM_OUT_WE), 64'd0);
    check("mid_rst_addr", 64'({RAM_OBJ_A, RAM_NBR_A, RAM_OUT_A}), 64'd0);
    wr_at_reset = writes;
    step(); step(); step();
    check("mid_no_more_writes", 64'(writes), 64'(wr_at_reset));
    check("mid_v3_untouched", 64'(out_mem[6]), 64'hDEADBEEF);
    check("mid_sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    rst_n = 1'b1;
    step();

    // Restart after the abort begins again at vertex 1.
    vertex_count = 32'd1;
    push_vertex(1, 3);
    clear_counters();
    pulse_start();
    run_pass("restart", 600);
    check("restart_first_nbr_addr", 64'(first_nbr_a), 64'd0);
    check("restart_v3_untouched", 64'(out_mem[8]), 64'hDEADBEEF);

    // A start pulse during a pass is ignored.
    vertex_count = 32'd1;
    push_vertex(1, 3);
    clear_counters();
    pulse_start();
    step(); step(); step();
    pulse_start();
    run_pass("busy_start", 600);
    for (int i = 0; i < 20; i++) step();
    check("busy_start_done_count", 64'(done_pulses), 64'd1);
    check("busy_start_writes", 64'(writes), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
